sum_reader: RTL and testbench

SUM_READER -- requirements
Module: sum_reader

---
 rtl/sum_reader.sv | 104 ++++++++++
 tb/tb_sum_reader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sum_reader.sv
// Serialises a captured vector of signed accumulator lanes into scaled, saturated output words.
// The design accepts a new frame in the same cycle that the previous frame's last word is taken.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no frame held; sum_ready high, out_valid low
// ST_EMIT | holding a frame; presenting lane out_index until it is taken
module sum_reader #(
    parameter int LANES  = 16,
    parameter int LANE_W = 32,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*LANE_W-1:0]   sum_in,
    input  logic                      sum_valid,
    output logic                      sum_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [3:0]                out_index,
    output logic                      out_last,
    output logic                      out_sat,
    output logic [15:0]               frame_cnt
);

    typedef enum logic {ST_IDLE, ST_EMIT} state_t;

    localparam logic [3:0] LAST_IDX = 4'(LANES - 1);
    localparam logic signed [LANE_W-1:0] SAT_MAX = LANE_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [LANE_W-1:0] SAT_MIN = LANE_W'(-(64'sd1 <<< (OUT_W - 1)));

    state_t             state_q;
    logic [LANE_W-1:0]  hold_q [LANES];
    logic               take;
    logic               take_last;
    logic               accept;
    logic [3:0]         next_idx;
    logic [OUT_W:0]     first_word;
    logic [OUT_W:0]     next_word;

    // Returns {sat, data}: lane shifted arithmetically, then clipped to the output range.
    function automatic logic [OUT_W:0] scale_lane(input logic [LANE_W-1:0] lane);
        logic signed [LANE_W-1:0] t;
        t = $signed(lane) >>> SHIFT;
        if (t > SAT_MAX)
            return {1'b1, SAT_MAX[OUT_W-1:0]};
        else if (t < SAT_MIN)
            return {1'b1, SAT_MIN[OUT_W-1:0]};
        else
            return {1'b0, t[OUT_W-1:0]};
    endfunction

    assign take      = out_valid && out_ready;
    assign take_last = take && out_last;
    assign sum_ready = !rst && ((state_q == ST_IDLE) || take_last);
    assign accept    = sum_valid && sum_ready;

    // Lane 0 of a newly accepted frame comes straight from sum_in so it appears one cycle after accept.
    always_comb begin
        next_idx   = out_index + 4'd1;
        first_word = scale_lane(sum_in[LANE_W-1:0]);
        next_word  = scale_lane(hold_q[next_idx]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
            frame_cnt <= '0;
            for (int i = 0; i < LANES; i++)
                hold_q[i] <= '0;
        end else begin
            if (take_last)
                frame_cnt <= frame_cnt + 16'd1;

            if (accept) begin
                for (int i = 0; i < LANES; i++)
                    hold_q[i] <= sum_in[i*LANE_W +: LANE_W];
                state_q   <= ST_EMIT;
                out_valid <= 1'b1;
                out_index <= '0;
                out_last  <= (LANES == 1);
                out_data  <= first_word[OUT_W-1:0];
                out_sat   <= first_word[OUT_W];
            end else if (take_last) begin
                state_q   <= ST_IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (take) begin
                out_index <= next_idx;
                out_last  <= (next_idx == LAST_IDX);
                out_data  <= next_word[OUT_W-1:0];
                out_sat   <= next_word[OUT_W];
            end
        end
    end

endmodule

// File: tb/tb_sum_reader.sv
// Directed bench for sum_reader: each task drives one scenario and checks outputs inline.
module tb_sum_reader;

    logic         clk;
    logic         rst;
    logic [511:0] sum_in;
    logic         sum_valid;
    logic         sum_ready;
    logic [15:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_index;
    logic         out_last;
    logic         out_sat;
    logic [15:0]  frame_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] lane_v [16];

    sum_reader dut (
        .clk       (clk),
        .rst       (rst),
        .sum_in    (sum_in),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .out_sat   (out_sat),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_frame();
        for (int i = 0; i < 16; i++)
            sum_in[i*32 +: 32] = lane_v[i];
    endtask

    task automatic test_reset();
        rst = 1'b1; sum_valid = 1'b0; out_ready = 1'b0; sum_in = '0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h expected 0000", out_data); end
        checks++; if (out_index !== 4'd0) begin errors++; $display("FAIL reset_index: got %0d expected 0", out_index); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_fcnt: got %0d expected 0", frame_cnt); end
        checks++; if (sum_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", sum_ready); end
        rst = 1'b0; #1;
        checks++; if (sum_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", sum_ready); end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 16; i++) lane_v[i] = 32'(i) << 8;
        pack_frame();
        sum_valid = 1'b1; out_ready = 1'b1;
        tick();
        sum_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ramp_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_data !== 16'(i)) begin errors++; $display("FAIL ramp_data[%0d]: got %h expected %h", i, out_data, 16'(i)); end
            checks++; if (out_index !== 4'(i)) begin errors++; $display("FAIL ramp_index[%0d]: got %0d expected %0d", i, out_index, i); end
            checks++; if (out_last !== (i == 15)) begin errors++; $display("FAIL ramp_last[%0d]: got %b expected %b", i, out_last, (i == 15)); end
            checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL ramp_sat[%0d]: got %b expected 0", i, out_sat); end
            checks++; if (sum_ready !== (i == 15)) begin errors++; $display("FAIL ramp_ready[%0d]: got %b expected %b", i, sum_ready, (i == 15)); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ramp_end_valid: got %b expected 0", out_valid); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL ramp_fcnt: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_saturation();
        logic [15:0] exp_d [7];
        logic        exp_s [7];
        lane_v = '{default: 32'h0};
        lane_v[0] = 32'h7FFFFFFF; exp_d[0] = 16'h7FFF; exp_s[0] = 1'b1;
        lane_v[1] = 32'h80000000; exp_d[1] = 16'h8000; exp_s[1] = 1'b1;
        lane_v[2] = 32'hFFFFFF00; exp_d[2] = 16'hFFFF; exp_s[2] = 1'b0;
        lane_v[3] = 32'h007FFF00; exp_d[3] = 16'h7FFF; exp_s[3] = 1'b0;
        lane_v[4] = 32'h00800000; exp_d[4] = 16'h7FFF; exp_s[4] = 1'b1;
        lane_v[5] = 32'hFF800000; exp_d[5] = 16'h8000; exp_s[5] = 1'b0;
        lane_v[6] = 32'hFF7FFFFF; exp_d[6] = 16'h8000; exp_s[6] = 1'b1;
        pack_frame();
        sum_valid = 1'b1; out_ready = 1'b1;
        tick();
        sum_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < 7) begin
                checks++; if (out_data !== exp_d[i]) begin errors++; $display("FAIL sat_data[%0d]: got %h expected %h", i, out_data, exp_d[i]); end
                checks++; if (out_sat !== exp_s[i]) begin errors++; $display("FAIL sat_flag[%0d]: got %b expected %b", i, out_sat, exp_s[i]); end
            end else begin
                checks++; if (out_data !== 16'h0 || out_sat !== 1'b0) begin errors++; $display("FAIL sat_zero[%0d]: got %h/%b expected 0000/0", i, out_data, out_sat); end
            end
            tick();
        end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL sat_fcnt: got %0d expected 2", frame_cnt); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 16; i++) lane_v[i] = 32'(i + 100) << 8;
        pack_frame();
        sum_valid = 1'b1; out_ready = 1'b1;
        tick();
        sum_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (out_index !== 4'd3 || out_data !== 16'd103) begin errors++; $display("FAIL bp_lane3: got %0d/%0d expected 3/103", out_index, out_data); end
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) sum_in[i*32 +: 32] = 32'h00AAAA00;
        sum_valid = 1'b1;
        #1;
        checks++; if (sum_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", sum_ready); end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_index !== 4'd3 || out_data !== 16'd103 || out_last !== 1'b0 || out_sat !== 1'b0)
                begin errors++; $display("FAIL bp_hold[%0d]: got v%b i%0d d%0d l%b s%b expected v1 i3 d103 l0 s0", k, out_valid, out_index, out_data, out_last, out_sat); end
        end
        sum_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_index !== 4'd4 || out_data !== 16'd104) begin errors++; $display("FAIL bp_lane4: got %0d/%0d expected 4/104", out_index, out_data); end
        for (int i = 5; i < 16; i++) begin
            tick();
            checks++; if (out_index !== 4'(i) || out_data !== 16'(i + 100)) begin errors++; $display("FAIL bp_drain[%0d]: got %0d/%0d expected %0d/%0d", i, out_index, out_data, i, i + 100); end
        end
        tick();
        checks++; if (out_valid !== 1'b0 || frame_cnt !== 16'd3) begin errors++; $display("FAIL bp_end: got v%b fcnt %0d expected v0 fcnt 3", out_valid, frame_cnt); end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 16; i++) lane_v[i] = 32'(i + 1) << 8;
        pack_frame();
        sum_valid = 1'b1; out_ready = 1'b1;
        tick();
        sum_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        checks++; if (out_index !== 4'd15 || out_data !== 16'd16 || out_last !== 1'b1) begin errors++; $display("FAIL b2b_lastA: got %0d/%0d/%b expected 15/16/1", out_index, out_data, out_last); end
        for (int i = 0; i < 16; i++) lane_v[i] = 32'(i + 200) << 8;
        pack_frame();
        sum_valid = 1'b1;
        #1;
        checks++; if (sum_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", sum_ready); end
        tick();
        sum_valid = 1'b0;
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL b2b_fcnt1: got %0d expected 1", frame_cnt); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (out_valid !== 1'b1 || out_index !== 4'(i) || out_data !== 16'(i + 200))
                begin errors++; $display("FAIL b2b_B[%0d]: got v%b %0d/%0d expected v1 %0d/%0d", i, out_valid, out_index, out_data, i, i + 200); end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || frame_cnt !== 16'd2) begin errors++; $display("FAIL b2b_end: got v%b fcnt %0d expected v0 fcnt 2", out_valid, frame_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 16; i++) lane_v[i] = 32'(i + 50) << 8;
        pack_frame();
        sum_valid = 1'b1; out_ready = 1'b1;
        tick();
        sum_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        out_ready = 1'b0;
        checks++; if (out_index !== 4'd7 || out_data !== 16'd57) begin errors++; $display("FAIL rmf_lane7: got %0d/%0d expected 7/57", out_index, out_data); end
        rst = 1'b1;
        #1;
        checks++; if (sum_ready !== 1'b0) begin errors++; $display("FAIL rmf_ready: got %b expected 0", sum_ready); end
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || frame_cnt !== 16'd0 || out_index !== 4'd0)
            begin errors++; $display("FAIL rmf_cleared: got v%b fcnt %0d idx %0d expected v0 fcnt 0 idx 0", out_valid, frame_cnt, out_index); end
        for (int i = 0; i < 16; i++) lane_v[i] = 32'(i + 300) << 8;
        pack_frame();
        sum_valid = 1'b1;
        tick();
        sum_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd0 || out_data !== 16'd300) begin errors++; $display("FAIL rmf_restart: got v%b %0d/%0d expected v1 0/300", out_valid, out_index, out_data); end
        for (int i = 0; i < 16; i++) tick();
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rmf_fcnt: got %0d expected 1", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
